// File: rtl/logic_unit_pkg.sv
// Shared constants and types for the logic/shift execution stage.
// No logic; opcode map, FSM encoding and datapath widths.
// Used by logic_bank and logic_shift_unit.
package logic_unit_pkg;

    localparam int DATA_W  = 32;
    localparam int SHAMT_W = 5;

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_NOR  = 3'd2;
    localparam logic [2:0] OP_NOT  = 3'd3;
    localparam logic [2:0] OP_SLL  = 3'd4;
    localparam logic [2:0] OP_SRL  = 3'd5;
    localparam logic [2:0] OP_SRA  = 3'd6;
    localparam logic [2:0] OP_RSVD = 3'd7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/AND32_2x1.sv
// 32-bit two-input AND gate array.
// Combinational, zero latency.
// No flow control.
module AND32_2x1 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);
    assign y = a & b;
endmodule

// File: rtl/INV32_1x1.sv
// 32-bit inverter array.
// Combinational, zero latency.
// No flow control.
module INV32_1x1 (
    input  logic [31:0] a,
    output logic [31:0] y
);
    assign y = ~a;
endmodule

// File: rtl/NOR32_2x1.sv
// 32-bit two-input NOR gate array.
// Combinational, zero latency.
// No flow control.
module NOR32_2x1 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);
    assign y = ~(a | b);
endmodule

// File: rtl/OR32_2x1.sv
// 32-bit two-input OR gate array.
// Combinational, zero latency.
// No flow control.
module OR32_2x1 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);
    assign y = a | b;
endmodule

// File: rtl/logic_bank.sv
// Bitwise gate arrays (AND/OR/NOR/NOT) with a 4:1 result select.
// Purely combinational, zero latency.
// No flow control; the caller registers the selected value.
module logic_bank
    import logic_unit_pkg::*;
(
    input  logic [1:0]        sel,
    input  logic [DATA_W-1:0] op1,
    input  logic [DATA_W-1:0] op2,
    output logic [DATA_W-1:0] y
);
    logic [DATA_W-1:0] and_y;
    logic [DATA_W-1:0] or_y;
    logic [DATA_W-1:0] nor_y;
    logic [DATA_W-1:0] inv_y;

    AND32_2x1 u_and (.a(op1), .b(op2), .y(and_y));
    OR32_2x1  u_or  (.a(op1), .b(op2), .y(or_y));
    NOR32_2x1 u_nor (.a(op1), .b(op2), .y(nor_y));
    INV32_1x1 u_inv (.a(op1), .y(inv_y));

    // Select on the low opcode bits; the opcode map puts AND/OR/NOR/NOT at 0..3.
    always_comb begin
        y = and_y;
        case (sel)
            2'd0:    y = and_y;
            2'd1:    y = or_y;
            2'd2:    y = nor_y;
            default: y = inv_y;
        endcase
    end
endmodule

// File: rtl/logic_shift_unit.sv
// ALU stage: bitwise ops via logic_bank plus a one-bit-per-cycle shifter.
// Latency 1 for logic/reserved ops, 1+shamt for shifts.
// Input accepted only in IDLE; result held in DONE until OUT_READY.
module logic_shift_unit
    import logic_unit_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    input  logic              IN_VALID,
    output logic              IN_READY,
    input  logic [2:0]        OPCODE,
    input  logic [DATA_W-1:0] OP1,
    input  logic [DATA_W-1:0] OP2,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic [DATA_W-1:0] RESULT,
    output logic              ZERO
);
    state_t             state_q;
    state_t             state_d;
    logic [DATA_W-1:0]  result_q;
    logic [DATA_W-1:0]  bank_y;
    logic [DATA_W-1:0]  logic_y;
    logic [DATA_W-1:0]  shift_y;
    logic [SHAMT_W-1:0] count_q;
    logic [2:0]         op_q;
    logic               ready_en_q;
    logic               accept;
    logic               is_shift;

    logic_bank u_bank (
        .sel (OPCODE[1:0]),
        .op1 (OP1),
        .op2 (OP2),
        .y   (bank_y)
    );

    // ready_en_q keeps IN_READY low during reset and until the first edge after release.
    assign IN_READY  = ready_en_q && (state_q == IDLE);
    assign OUT_VALID = (state_q == DONE);
    assign RESULT    = result_q;
    assign ZERO      = (result_q == '0);
    assign accept    = IN_VALID && IN_READY;
    assign is_shift  = (OPCODE == OP_SLL) || (OPCODE == OP_SRL) || (OPCODE == OP_SRA);
    // Reserved opcode shares bit pattern 3'b111 with NOT in the bank select, so force zero.
    assign logic_y   = (OPCODE == OP_RSVD) ? '0 : bank_y;

    // One-position shift of the held result in the latched direction.
    always_comb begin
        shift_y = result_q;
        case (op_q)
            OP_SLL:  shift_y = {result_q[DATA_W-2:0], 1'b0};
            OP_SRL:  shift_y = {1'b0, result_q[DATA_W-1:1]};
            OP_SRA:  shift_y = {result_q[DATA_W-1], result_q[DATA_W-1:1]};
            default: shift_y = result_q;
        endcase
    end

    // State register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a zero shift amount skips SHIFT entirely.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (is_shift && (OP2[SHAMT_W-1:0] != '0)) begin
                        state_d = SHIFT;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            SHIFT: begin
                if (count_q == SHAMT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (OUT_READY) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath: load on accept, shift and count down in SHIFT, hold otherwise.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            result_q   <= '0;
            count_q    <= '0;
            op_q       <= OP_AND;
            ready_en_q <= 1'b0;
        end else begin
            ready_en_q <= 1'b1;
            if (state_q == IDLE && accept) begin
                if (is_shift) begin
                    result_q <= OP1;
                    count_q  <= OP2[SHAMT_W-1:0];
                    op_q     <= OPCODE;
                end else begin
                    result_q <= logic_y;
                end
            end else if (state_q == SHIFT) begin
                result_q <= shift_y;
                count_q  <= count_q - SHAMT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_logic_shift_unit.sv
// Directed self-checking bench for logic_shift_unit.
// Latency counted in rising edges, the accept edge being edge 1.
// Outputs sampled 1 time unit after the rising edge.
module tb_logic_shift_unit;
    import logic_unit_pkg::*;

    logic        CLK = 1'b0;
    logic        RST;
    logic        IN_VALID;
    logic        IN_READY;
    logic [2:0]  OPCODE;
    logic [31:0] OP1;
    logic [31:0] OP2;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic [31:0] RESULT;
    logic        ZERO;

    int checks = 0;
    int errors = 0;

    logic_shift_unit dut (
        .CLK       (CLK),
        .RST       (RST),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .OPCODE    (OPCODE),
        .OP1       (OP1),
        .OP2       (OP2),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .RESULT    (RESULT),
        .ZERO      (ZERO)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Present one operation for one edge; scramble operands afterwards.
    task automatic issue(input string tag, input logic [2:0] opc,
                         input logic [31:0] a, input logic [31:0] b);
        check({tag, "_in_ready"}, {31'd0, IN_READY}, 32'd1);
        IN_VALID = 1'b1;
        OPCODE   = opc;
        OP1      = a;
        OP2      = b;
        tick();
        IN_VALID = 1'b0;
        OP1      = $urandom;
        OP2      = $urandom;
        OPCODE   = 3'($urandom_range(0, 7));
    endtask

    // Count edges until OUT_VALID, bounded; report latency and whether IN_READY was seen.
    task automatic wait_valid(input int max_edges, output int lat, output bit rdy_seen);
        lat      = 1;
        rdy_seen = IN_READY;
        while (!OUT_VALID && lat < max_edges + 2) begin
            tick();
            lat++;
            if (IN_READY) rdy_seen = 1'b1;
        end
    endtask

    task automatic handshake(input string tag);
        OUT_READY = 1'b1;
        tick();
        OUT_READY = 1'b0;
        check({tag, "_vld_drop"}, {31'd0, OUT_VALID}, 32'd0);
        check({tag, "_rdy_rise"}, {31'd0, IN_READY}, 32'd1);
    endtask

    task automatic run_op(input string tag, input logic [2:0] opc,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int exp_lat);
        int lat;
        bit rdy_seen;
        issue(tag, opc, a, b);
        wait_valid(exp_lat, lat, rdy_seen);
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_result"}, RESULT, exp);
        check({tag, "_zero"}, {31'd0, ZERO}, {31'd0, exp == 32'd0});
        check({tag, "_busy_rdy"}, {31'd0, rdy_seen}, 32'd0);
        handshake(tag);
    endtask

    initial begin
        int lat;
        bit rdy_seen;
        logic [31:0] held;

        RST       = 1'b0;
        IN_VALID  = 1'b0;
        OPCODE    = OP_AND;
        OP1       = '0;
        OP2       = '0;
        OUT_READY = 1'b0;

        // Reset state.
        tick();
        tick();
        check("rst_out_valid", {31'd0, OUT_VALID}, 32'd0);
        check("rst_result", RESULT, 32'd0);
        check("rst_zero", {31'd0, ZERO}, 32'd1);
        check("rst_in_ready", {31'd0, IN_READY}, 32'd0);
        RST = 1'b1;
        #1;
        check("rel_in_ready_before_edge", {31'd0, IN_READY}, 32'd0);
        tick();
        check("rel_in_ready_after_edge", {31'd0, IN_READY}, 32'd1);

        // Logic ops and reserved opcode.
        run_op("and",  OP_AND,  32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234, 1);
        run_op("nor",  OP_NOR,  32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1);
        run_op("or",   OP_OR,   32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1);
        run_op("or2",  OP_OR,   32'h1200_0034, 32'h0056_7800, 32'h1256_7834, 1);
        run_op("not",  OP_NOT,  32'h1234_5678, 32'hFFFF_FFFF, 32'hEDCB_A987, 1);
        run_op("rsvd", OP_RSVD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1);

        // Shifts; upper OP2 bits ignored.
        run_op("sra4",  OP_SRA, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000, 5);
        run_op("srl4",  OP_SRL, 32'h8000_0000, 32'h0000_0024, 32'h0800_0000, 5);
        run_op("sra_p", OP_SRA, 32'h4000_0000, 32'hFFFF_FFE2, 32'h1000_0000, 3);
        run_op("sll0",  OP_SLL, 32'h0000_0001, 32'h0000_0000, 32'h0000_0001, 1);
        run_op("sll3",  OP_SLL, 32'h0000_00F1, 32'h1234_5603, 32'h0000_0788, 4);

        // Shamt 31 with IN_VALID held during the shift; it must be ignored.
        issue("sll31", OP_SLL, 32'h0000_0001, 32'hABCD_EF1F);
        IN_VALID = 1'b1;
        OPCODE   = OP_AND;
        OP1      = 32'hFFFF_FFFF;
        OP2      = 32'hFFFF_FFFF;
        wait_valid(32, lat, rdy_seen);
        IN_VALID = 1'b0;
        check("sll31_latency", lat, 32);
        check("sll31_result", RESULT, 32'h8000_0000);
        check("sll31_busy_rdy", {31'd0, rdy_seen}, 32'd0);
        handshake("sll31");

        // Backpressure in DONE.
        issue("bp", OP_AND, 32'hDEAD_BEEF, 32'h00FF_FF00);
        wait_valid(1, lat, rdy_seen);
        check("bp_latency", lat, 1);
        held = RESULT;
        check("bp_result", held, 32'h00AD_BE00);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_hold_result", RESULT, 32'h00AD_BE00);
            check("bp_hold_zero", {31'd0, ZERO}, 32'd0);
            check("bp_hold_valid", {31'd0, OUT_VALID}, 32'd1);
            check("bp_hold_in_rdy", {31'd0, IN_READY}, 32'd0);
        end
        handshake("bp");

        // Reset in the middle of a long shift.
        issue("mid", OP_SLL, 32'h0000_0001, 32'h0000_001F);
        for (int i = 0; i < 10; i++) tick();
        check("mid_still_busy", {31'd0, OUT_VALID}, 32'd0);
        RST = 1'b0;
        #1;
        check("mid_rst_valid", {31'd0, OUT_VALID}, 32'd0);
        check("mid_rst_result", RESULT, 32'd0);
        check("mid_rst_zero", {31'd0, ZERO}, 32'd1);
        check("mid_rst_in_ready", {31'd0, IN_READY}, 32'd0);
        tick();
        tick();
        RST = 1'b1;
        tick();
        check("mid_rel_in_ready", {31'd0, IN_READY}, 32'd1);
        rdy_seen = 1'b0;
        for (int i = 0; i < 35; i++) begin
            if (OUT_VALID) rdy_seen = 1'b1;
            tick();
        end
        check("mid_no_stale_valid", {31'd0, rdy_seen}, 32'd0);
        check("mid_result_cleared", RESULT, 32'd0);
        run_op("post_and", OP_AND, 32'hA5A5_A5A5, 32'hFFFF_0000, 32'hA5A5_0000, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
